// File: rtl/seq_restoring_divider.sv
// Sequential unsigned restoring divider: one quotient bit per clock, MSB first.
// Recovers an operand from a (possibly approximate) product and reports the residue.
module seq_restoring_divider #(
    parameter int unsigned DIVIDEND_W = 16,
    parameter int unsigned DIVISOR_W  = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DIVIDEND_W-1:0] in_dividend,
    input  logic [DIVISOR_W-1:0]  in_divisor,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DIVIDEND_W-1:0] out_quotient,
    output logic [DIVISOR_W-1:0]  out_remainder,
    output logic                  out_exact,
    output logic                  out_div_zero
);

    localparam int unsigned CNT_W = (DIVIDEND_W > 1) ? $clog2(DIVIDEND_W) : 1;

    typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

    state_e                state_q;
    logic [DIVIDEND_W-1:0] quo_q;
    logic [DIVISOR_W:0]    rem_q;
    logic [DIVISOR_W-1:0]  dvs_q;
    logic [CNT_W-1:0]      cnt_q;
    logic                  dz_q;

    logic [DIVISOR_W:0]    rem_shift;
    logic [DIVISOR_W:0]    rem_sub;
    logic                  rem_ge;

    always_comb begin
        rem_shift = {rem_q[DIVISOR_W-1:0], quo_q[DIVIDEND_W-1]};
        rem_sub   = rem_shift - {1'b0, dvs_q};
        rem_ge    = (rem_shift >= {1'b0, dvs_q});
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= StIdle;
            in_ready      <= 1'b1;
            out_valid     <= 1'b0;
            out_quotient  <= '0;
            out_remainder <= '0;
            out_exact     <= 1'b0;
            out_div_zero  <= 1'b0;
            quo_q         <= '0;
            rem_q         <= '0;
            dvs_q         <= '0;
            cnt_q         <= '0;
            dz_q          <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (in_valid && in_ready) begin
                        in_ready <= 1'b0;
                        dvs_q    <= in_divisor;
                        cnt_q    <= CNT_W'(DIVIDEND_W - 1);
                        // Divide-by-zero skips iteration; the working registers carry the result.
                        if (in_divisor == '0) begin
                            quo_q   <= '1;
                            rem_q   <= {1'b0, in_dividend[DIVISOR_W-1:0]};
                            dz_q    <= 1'b1;
                            state_q <= StDone;
                        end else begin
                            quo_q   <= in_dividend;
                            rem_q   <= '0;
                            dz_q    <= 1'b0;
                            state_q <= StBusy;
                        end
                    end
                end
                StBusy: begin
                    quo_q <= {quo_q[DIVIDEND_W-2:0], rem_ge};
                    rem_q <= rem_ge ? rem_sub : rem_shift;
                    if (cnt_q == '0) begin
                        state_q <= StDone;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                StDone: begin
                    // First DONE cycle publishes the result; outputs then hold until taken.
                    if (!out_valid) begin
                        out_quotient  <= quo_q;
                        out_remainder <= rem_q[DIVISOR_W-1:0];
                        out_exact     <= !dz_q && (rem_q == '0);
                        out_div_zero  <= dz_q;
                        out_valid     <= 1'b1;
                    end else if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state_q   <= StIdle;
                    end
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule
